cpu_mmu_miss_seq: RTL

CPU_MMU_MISS_SEQ -- requirements
Module: cpu_mmu_miss_seq

---
 rtl/cpu_mmu_miss_pkg.sv | 26 ++
 rtl/cpu_mmu_miss_seq_sat_cnt16.sv | 34 +++
 rtl/cpu_mmu_miss_seq.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/cpu_mmu_miss_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_mmu_miss_pkg
//  Purpose  : Shared types and constants for the MMU miss sequencer:
//             FSM state enumeration, timeout terminal count, counter widths.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_mmu_miss_pkg;

    localparam int TIMEOUT_MAX = 255;
    localparam int TMO_W       = 8;
    localparam int CNT_W       = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMP  = 3'd1,
        EVAL = 3'd2,
        FILL = 3'd3,
        UPD  = 3'd4,
        DONE = 3'd5,
        ERR  = 3'd6
    } state_e;

endpackage : cpu_mmu_miss_pkg
`default_nettype wire

// File: rtl/cpu_mmu_miss_seq_sat_cnt16.sv
`default_nettype none
// ============================================================================
//  Module   : sat_cnt16
//  Purpose  : 16-bit event counter that sticks at all-ones instead of
//             wrapping. Asynchronous active-low clear.
//  Ports    : clk_i  - clock
//             rst_ni - asynchronous active-low clear
//             inc_i  - increment enable (one count per cycle)
//             cnt_o  - current count
//  Revision : 1.0 - initial release
// ============================================================================
module sat_cnt16
    import cpu_mmu_miss_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule : sat_cnt16
`default_nettype wire

// File: rtl/cpu_mmu_miss_seq.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_mmu_miss_seq
//  Purpose  : Cache miss sequencer between a CPU, a two-half tag comparator
//             and memory. Handles read hits, read-miss line fill with tag
//             update, write-through (no allocate) writes, cache bypass,
//             memory error and fill timeout. Keeps saturating hit/miss counts.
//  Ports    : sysclk, sys_rst_n          - clock, async active-low reset
//             REQ, WRITE, CACHE_EN       - CPU request, type, cache enable
//             HIT0_n, HIT1_n             - active-low tag compare results
//             MEM_ACK, MEM_ERR           - memory completion / error
//             CON_n, FMISS               - active-low compare enables
//             MEM_REQ, TAG_WE            - memory request, tag write strobe
//             CPU_RDY, CPU_ERR           - completion / error pulses
//             BUSY, HIT_CNT, MISS_CNT    - status and statistics
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_mmu_miss_seq
    import cpu_mmu_miss_pkg::*;
(
    input  logic             sysclk,
    input  logic             sys_rst_n,
    input  logic             REQ,
    input  logic             WRITE,
    input  logic             CACHE_EN,
    input  logic             HIT0_n,
    input  logic             HIT1_n,
    input  logic             MEM_ACK,
    input  logic             MEM_ERR,
    output logic             CON_n,
    output logic             FMISS,
    output logic             MEM_REQ,
    output logic             TAG_WE,
    output logic             CPU_RDY,
    output logic             CPU_ERR,
    output logic             BUSY,
    output logic [CNT_W-1:0] HIT_CNT,
    output logic [CNT_W-1:0] MISS_CNT
);

    state_e             state_q, state_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               write_q, write_d;
    logic               bypass_q, bypass_d;
    logic               hit;
    logic               hit_inc, miss_inc;

    // Output registers: each is decoded from the next state so the pin
    // reflects the state the FSM is in during that cycle.
    logic con_n_q, fmiss_q, mem_req_q, tag_we_q, cpu_rdy_q, cpu_err_q, busy_q;
    logic cmp_d;

    assign hit = !HIT0_n && !HIT1_n;

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        bypass_d = bypass_q;
        tmo_d    = '0;
        hit_inc  = 1'b0;
        miss_inc = 1'b0;

        case (state_q)
            IDLE: begin
                if (REQ) begin
                    // Capture the access attributes once; the FSM relies on
                    // them later even though the CPU holds them stable.
                    write_d  = WRITE;
                    bypass_d = !CACHE_EN;
                    state_d  = CACHE_EN ? CMP : FILL;
                end
            end
            CMP:  state_d = EVAL;
            EVAL: begin
                if (hit) begin
                    hit_inc = 1'b1;
                    state_d = write_q ? FILL : DONE;
                end else begin
                    miss_inc = 1'b1;
                    state_d  = FILL;
                end
            end
            FILL: begin
                tmo_d = tmo_q + 1'b1;
                // Priority: error beats acknowledge, acknowledge beats timeout.
                if (MEM_ERR) begin
                    state_d = ERR;
                end else if (MEM_ACK) begin
                    state_d = (write_q || bypass_q) ? DONE : UPD;
                end else if (tmo_q == TMO_W'(TIMEOUT_MAX)) begin
                    state_d = ERR;
                end
            end
            UPD:     state_d = DONE;
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign cmp_d = (state_d == CMP) || (state_d == EVAL);

    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            tmo_q     <= '0;
            write_q   <= 1'b0;
            bypass_q  <= 1'b0;
            con_n_q   <= 1'b1;
            fmiss_q   <= 1'b1;
            mem_req_q <= 1'b0;
            tag_we_q  <= 1'b0;
            cpu_rdy_q <= 1'b0;
            cpu_err_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            write_q   <= write_d;
            bypass_q  <= bypass_d;
            con_n_q   <= !cmp_d;
            fmiss_q   <= !cmp_d;
            mem_req_q <= (state_d == FILL);
            tag_we_q  <= (state_d == UPD);
            cpu_rdy_q <= (state_d == DONE) || (state_d == ERR);
            cpu_err_q <= (state_d == ERR);
            busy_q    <= (state_d != IDLE);
        end
    end

    assign CON_n   = con_n_q;
    assign FMISS   = fmiss_q;
    assign MEM_REQ = mem_req_q;
    assign TAG_WE  = tag_we_q;
    assign CPU_RDY = cpu_rdy_q;
    assign CPU_ERR = cpu_err_q;
    assign BUSY    = busy_q;

    sat_cnt16 u_hit_cnt (
        .clk_i  (sysclk),
        .rst_ni (sys_rst_n),
        .inc_i  (hit_inc),
        .cnt_o  (HIT_CNT)
    );

    sat_cnt16 u_miss_cnt (
        .clk_i  (sysclk),
        .rst_ni (sys_rst_n),
        .inc_i  (miss_inc),
        .cnt_o  (MISS_CNT)
    );

endmodule : cpu_mmu_miss_seq
`default_nettype wire
